// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and optional 2-entry skid buffer.
// With SKID=1 in_ready comes straight from a flop; with SKID=0 it is combinational.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_q;
  logic              accept, pop;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign level     = state_reg;  // encoding doubles as occupancy count
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    if (flush) begin
      state_next = EMPTY;
      main_next  = BUBBLE_VAL;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_next = in_data;
          end else if (accept && SKID) begin
            state_next = TWO;
          end else if (pop) begin
            state_next = EMPTY;
            main_next  = BUBBLE_VAL;
          end
        end
        TWO: begin
          if (pop) begin
            state_next = ONE;
            main_next  = skid_q;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      main_reg  <= BUBBLE_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
    end
  end

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              ready_reg;

    always_comb begin
      skid_next = skid_reg;
      if (flush) begin
        skid_next = BUBBLE_VAL;
      end else if (state_reg == ONE && accept && !pop) begin
        skid_next = in_data;
      end else if (state_reg == TWO && pop) begin
        skid_next = BUBBLE_VAL;
      end
    end

    // Ready is registered from the next state so no combinational path reaches upstream.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        skid_reg  <= BUBBLE_VAL;
        ready_reg <= 1'b1;
      end else begin
        skid_reg  <= skid_next;
        ready_reg <= (state_next != TWO);
      end
    end

    assign skid_q   = skid_reg;
    assign in_ready = ready_reg;
  end else begin : g_noskid
    assign skid_q   = BUBBLE_VAL;
    assign in_ready = ~out_valid | out_ready;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: instance 0 is SKID=0, instance 1 is SKID=1, both checked
// every cycle against a queue-style occupancy model plus hand-computed expectations.
module tb_pipe_stage_skid;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, flush, out_ready, send_en;
  logic         in_valid  [2];
  logic [W-1:0] in_data   [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   level     [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pipe_stage_skid #(
      .DATA_W    (W),
      .BUBBLE_VAL((gi == 1) ? 16'h0000 : 16'hB0B0),
      .SKID      (gi == 1)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .in_data  (in_data[gi]),
      .out_valid(out_valid[gi]),
      .out_ready(out_ready),
      .out_data (out_data[gi]),
      .level    (level[gi])
    );
  end

  int           checks = 0;
  int           errors = 0;
  int           cnt    [2];
  logic [W-1:0] fifo   [2][2];
  logic [W-1:0] src    [2][64];
  int           src_hd [2];
  int           src_tl [2];
  logic [W-1:0] plog   [2][64];
  int           pn     [2];

  function automatic logic [W-1:0] bub(input int i);
    return (i == 1) ? 16'h0000 : 16'hB0B0;
  endfunction

  function automatic bit skid(input int i);
    return i == 1;
  endfunction

  function automatic logic exp_ready(input int i);
    if (skid(i)) return cnt[i] < 2;
    return (cnt[i] == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input int i, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    for (int i = 0; i < 2; i++) begin
      src[i][src_tl[i]] = v;
      src_tl[i]++;
    end
  endtask

  task automatic empty_lit(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_out_valid"}, i, W'(out_valid[i]), W'(1'b0));
      chk({tag, "_out_data"},  i, out_data[i], bub(i));
      chk({tag, "_level"},     i, W'(level[i]), W'(2'd0));
      chk({tag, "_in_ready"},  i, W'(in_ready[i]), W'(1'b1));
    end
  endtask

  // Drive inputs, advance the model across the coming edge, then compare at the negedge.
  task automatic cycle();
    logic acc, pop;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = send_en && (src_hd[i] != src_tl[i]);
      in_data[i]  = in_valid[i] ? src[i][src_hd[i]] : W'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        cnt[i] = 0;
      end else begin
        acc = in_valid[i] && exp_ready(i);
        pop = (cnt[i] != 0) && out_ready;
        if (acc) src_hd[i]++;
        if (pop) begin
          plog[i][pn[i]] = fifo[i][0];
          pn[i]++;
          fifo[i][0] = fifo[i][1];
          cnt[i]--;
        end
        if (acc) begin
          fifo[i][cnt[i]] = in_data[i];
          cnt[i]++;
        end
        if (flush) cnt[i] = 0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) cnt[i] = 0;
      chk("out_valid", i, W'(out_valid[i]), W'(cnt[i] != 0));
      chk("out_data", i, out_data[i], (cnt[i] != 0) ? fifo[i][0] : bub(i));
      chk("level", i, W'(level[i]), W'(cnt[i]));
      chk("in_ready", i, W'(in_ready[i]), W'(exp_ready(i)));
      chk("level_bound", i, W'(level[i] <= (skid(i) ? 2'd2 : 2'd1)), W'(1'b1));
    end
  endtask

  task automatic check_log(input int i, input logic [W-1:0] e[$]);
    chk("pop_count", i, W'(pn[i]), W'(e.size()));
    for (int k = 0; k < e.size() && k < pn[i]; k++) chk("pop_order", i, plog[i][k], e[k]);
  endtask

  initial begin
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; send_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; src_hd[i] = 0; src_tl[i] = 0; pn[i] = 0;
      in_valid[i] = 1'b0; in_data[i] = '0;
      fifo[i][0] = '0; fifo[i][1] = '0;
    end

    // T1: reset with in_valid high, then first accept
    push(16'h000A);
    repeat (3) cycle();
    empty_lit("t1_reset");
    rst = 1'b1;
    cycle();
    for (int i = 0; i < 2; i++) chk("t1_first", i, out_data[i], 16'h000A);
    cycle();

    // T2: streaming
    for (int v = 1; v <= 8; v++) push(W'(v));
    repeat (8) begin
      cycle();
      for (int i = 0; i < 2; i++) chk("t2_level", i, W'(level[i]), W'(2'd1));
    end
    repeat (2) cycle();

    // T3: skid fill under stall
    out_ready = 1'b0;
    push(16'h0010); push(16'h0011); push(16'h0012);
    repeat (3) cycle();
    chk("t3_level", 1, W'(level[1]), W'(2'd2));
    chk("t3_in_ready", 1, W'(in_ready[1]), W'(1'b0));
    chk("t3_level", 0, W'(level[0]), W'(2'd1));
    chk("t3_in_ready", 0, W'(in_ready[0]), W'(1'b0));
    out_ready = 1'b1;
    repeat (5) cycle();

    // T4: long stall at level 1, upstream idle with junk data
    out_ready = 1'b0;
    push(16'h0020);
    cycle();
    send_en = 1'b0;
    push(16'h0021);
    repeat (20) begin
      cycle();
      for (int i = 0; i < 2; i++) chk("t4_hold", i, out_data[i], 16'h0020);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_comb_ready_hi", 0, W'(in_ready[0]), W'(1'b1));
    out_ready = 1'b0;
    #1;
    chk("t4_comb_ready_lo", 0, W'(in_ready[0]), W'(1'b0));
    chk("t4_reg_ready", 1, W'(in_ready[1]), W'(1'b1));
    send_en = 1'b1;
    out_ready = 1'b1;
    repeat (4) cycle();

    // T5: flush at level 2 with 0x55 presented, then flush with a pop and an accept
    out_ready = 1'b0;
    push(16'h0030); push(16'h0031); push(16'h0055);
    repeat (3) cycle();
    chk("t5_level", 1, W'(level[1]), W'(2'd2));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) src_hd[i] = src_tl[i];
    empty_lit("t5_flush");
    out_ready = 1'b1;
    push(16'h0040);
    cycle();
    push(16'h0066);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    empty_lit("t5_flush_pop");
    repeat (2) cycle();

    // T6: asynchronous reset between edges at level 2
    out_ready = 1'b0;
    push(16'h0070); push(16'h0071); push(16'h0072);
    repeat (3) cycle();
    chk("t6_level", 1, W'(level[1]), W'(2'd2));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    empty_lit("t6_async");
    cycle();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) cycle();

    exp1 = {16'h000A, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007,
            16'h0008, 16'h0010, 16'h0011, 16'h0012, 16'h0020, 16'h0021, 16'h0040, 16'h0072};
    exp0 = {16'h000A, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007,
            16'h0008, 16'h0010, 16'h0011, 16'h0012, 16'h0020, 16'h0021, 16'h0040, 16'h0071,
            16'h0072};
    check_log(1, exp1);
    check_log(0, exp0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
